// File: rtl/dcache_pmem_axi4lite.sv
// dcache_pmem_axi4lite: turns the single-beat outport request/ack bus of the
// dcache_if_pmem bridge into AXI4-Lite master transactions, one at a time.
// All AXI valids/readies and the ack/data back to the requester are registered.
// An optional response timeout turns a hung slave into an error ack.
module dcache_pmem_axi4lite #(
    parameter int TIMEOUT   = 0,
    parameter int TIMEOUT_W = 16
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [3:0]  inport_wr_i,
    input  logic        inport_rd_i,
    input  logic [7:0]  inport_len_i,
    input  logic [31:0] inport_addr_i,
    input  logic [31:0] inport_write_data_i,
    output logic        inport_accept_o,
    output logic        inport_ack_o,
    output logic        inport_error_o,
    output logic [31:0] inport_read_data_o,
    output logic        axi_awvalid_o,
    input  logic        axi_awready_i,
    output logic [31:0] axi_awaddr_o,
    output logic        axi_wvalid_o,
    input  logic        axi_wready_i,
    output logic [31:0] axi_wdata_o,
    output logic [3:0]  axi_wstrb_o,
    input  logic        axi_bvalid_i,
    output logic        axi_bready_o,
    input  logic [1:0]  axi_bresp_i,
    output logic        axi_arvalid_o,
    input  logic        axi_arready_i,
    output logic [31:0] axi_araddr_o,
    input  logic        axi_rvalid_i,
    output logic        axi_rready_o,
    input  logic [31:0] axi_rdata_i,
    input  logic [1:0]  axi_rresp_i
);

    typedef enum logic [2:0] {
        IDLE,
        WREQ,
        WRESP,
        RREQ,
        RRESP,
        ERR
    } state_t;

    // Counter value on the cycle whose closing edge makes it reach TIMEOUT.
    localparam logic [TIMEOUT_W-1:0] TMO_LAST =
        (TIMEOUT == 0) ? '0 : TIMEOUT_W'(TIMEOUT - 1);

    state_t              state_q, state_d;
    logic                awvalid_q, awvalid_d;
    logic                wvalid_q, wvalid_d;
    logic                bready_q, bready_d;
    logic                arvalid_q, arvalid_d;
    logic                rready_q, rready_d;
    logic                ack_q, ack_d;
    logic                error_q, error_d;
    logic [31:0]         rdata_q, rdata_d;
    logic [31:0]         addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [3:0]          strb_q, strb_d;
    logic [TIMEOUT_W-1:0] tmo_cnt_q, tmo_cnt_d;

    logic req;
    logic busy;
    logic tmo_hit;
    logic abort;
    logic aw_done;
    logic w_done;

    // Only the error bit of each response is meaningful to the requester.
    logic unused_resp_bits;
    assign unused_resp_bits = axi_bresp_i[0] ^ axi_rresp_i[0];

    assign req     = inport_rd_i || (inport_wr_i != 4'h0);
    assign busy    = (state_q == WREQ) || (state_q == WRESP) ||
                     (state_q == RREQ) || (state_q == RRESP);
    assign tmo_hit = (TIMEOUT != 0) && busy && (tmo_cnt_q == TMO_LAST);
    assign aw_done = !awvalid_q || axi_awready_i;
    assign w_done  = !wvalid_q || axi_wready_i;

    assign inport_accept_o    = (state_q == IDLE);
    assign inport_ack_o       = ack_q;
    assign inport_error_o     = error_q;
    assign inport_read_data_o = rdata_q;
    assign axi_awvalid_o      = awvalid_q;
    assign axi_awaddr_o       = addr_q;
    assign axi_wvalid_o       = wvalid_q;
    assign axi_wdata_o        = wdata_q;
    assign axi_wstrb_o        = strb_q;
    assign axi_bready_o       = bready_q;
    assign axi_arvalid_o      = arvalid_q;
    assign axi_araddr_o       = addr_q;
    assign axi_rready_o       = rready_q;

    // Next-state and next-output logic; a timeout abort overrides everything.
    always_comb begin
        state_d   = state_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        bready_d  = bready_q;
        arvalid_d = arvalid_q;
        rready_d  = rready_q;
        ack_d     = 1'b0;
        error_d   = 1'b0;
        rdata_d   = rdata_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        strb_d    = strb_q;
        tmo_cnt_d = tmo_cnt_q;
        abort     = 1'b0;

        if (busy && (tmo_cnt_q != '1)) begin
            tmo_cnt_d = tmo_cnt_q + TIMEOUT_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (req) begin
                    addr_d    = inport_addr_i;
                    wdata_d   = inport_write_data_i;
                    strb_d    = inport_wr_i;
                    tmo_cnt_d = '0;
                    if (inport_len_i != 8'd0) begin
                        state_d = ERR;
                    end else if (inport_wr_i != 4'h0) begin
                        state_d   = WREQ;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                    end else begin
                        state_d   = RREQ;
                        arvalid_d = 1'b1;
                    end
                end
            end
            WREQ: begin
                if (tmo_hit) begin
                    abort = 1'b1;
                end else if (aw_done && w_done) begin
                    awvalid_d = 1'b0;
                    wvalid_d  = 1'b0;
                    bready_d  = 1'b1;
                    state_d   = WRESP;
                end else begin
                    if (awvalid_q && axi_awready_i) begin
                        awvalid_d = 1'b0;
                    end
                    if (wvalid_q && axi_wready_i) begin
                        wvalid_d = 1'b0;
                    end
                end
            end
            WRESP: begin
                if (axi_bvalid_i) begin
                    bready_d = 1'b0;
                    ack_d    = 1'b1;
                    error_d  = axi_bresp_i[1];
                    state_d  = IDLE;
                end else if (tmo_hit) begin
                    abort = 1'b1;
                end
            end
            RREQ: begin
                if (tmo_hit) begin
                    abort = 1'b1;
                end else if (axi_arready_i) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = RRESP;
                end
            end
            RRESP: begin
                if (axi_rvalid_i) begin
                    rready_d = 1'b0;
                    rdata_d  = axi_rdata_i;
                    ack_d    = 1'b1;
                    error_d  = axi_rresp_i[1];
                    state_d  = IDLE;
                end else if (tmo_hit) begin
                    abort = 1'b1;
                end
            end
            ERR: begin
                ack_d   = 1'b1;
                error_d = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (abort) begin
            awvalid_d = 1'b0;
            wvalid_d  = 1'b0;
            bready_d  = 1'b0;
            arvalid_d = 1'b0;
            rready_d  = 1'b0;
            ack_d     = 1'b1;
            error_d   = 1'b1;
            state_d   = IDLE;
        end
    end

    // State and registered outputs; reset drops any in-flight request silently.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            ack_q     <= 1'b0;
            error_q   <= 1'b0;
            rdata_q   <= 32'h0;
            addr_q    <= 32'h0;
            wdata_q   <= 32'h0;
            strb_q    <= 4'h0;
            tmo_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            bready_q  <= bready_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
            ack_q     <= ack_d;
            error_q   <= error_d;
            rdata_q   <= rdata_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            strb_q    <= strb_d;
            tmo_cnt_q <= tmo_cnt_d;
        end
    end

endmodule

// File: tb/tb_dcache_pmem_axi4lite.sv
// tb_dcache_pmem_axi4lite: directed bench for the AXI4-Lite memory port.
// The design runs with TIMEOUT=8; every stall used below is shorter than that
// except in the dedicated timeout step.
module tb_dcache_pmem_axi4lite;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  wr;
    logic        rd;
    logic [7:0]  len;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        accept;
    logic        ack;
    logic        error;
    logic [31:0] read_data;
    logic        awvalid;
    logic        awready;
    logic [31:0] awaddr;
    logic        wvalid;
    logic        wready;
    logic [31:0] axi_wdata;
    logic [3:0]  wstrb;
    logic        bvalid;
    logic        bready;
    logic [1:0]  bresp;
    logic        arvalid;
    logic        arready;
    logic [31:0] araddr;
    logic        rvalid;
    logic        rready;
    logic [31:0] rdata;
    logic [1:0]  rresp;

    int total = 0;
    int bad = 0;
    int ack_count = 0;
    int n0;
    logic seen;

    always #5 clk = ~clk;

    dcache_pmem_axi4lite #(
        .TIMEOUT  (8),
        .TIMEOUT_W(16)
    ) dut (
        .clk_i              (clk),
        .rst_ni             (rst_n),
        .inport_wr_i        (wr),
        .inport_rd_i        (rd),
        .inport_len_i       (len),
        .inport_addr_i      (addr),
        .inport_write_data_i(wdata),
        .inport_accept_o    (accept),
        .inport_ack_o       (ack),
        .inport_error_o     (error),
        .inport_read_data_o (read_data),
        .axi_awvalid_o      (awvalid),
        .axi_awready_i      (awready),
        .axi_awaddr_o       (awaddr),
        .axi_wvalid_o       (wvalid),
        .axi_wready_i       (wready),
        .axi_wdata_o        (axi_wdata),
        .axi_wstrb_o        (wstrb),
        .axi_bvalid_i       (bvalid),
        .axi_bready_o       (bready),
        .axi_bresp_i        (bresp),
        .axi_arvalid_o      (arvalid),
        .axi_arready_i      (arready),
        .axi_araddr_o       (araddr),
        .axi_rvalid_i       (rvalid),
        .axi_rready_o       (rready),
        .axi_rdata_i        (rdata),
        .axi_rresp_i        (rresp)
    );

    // Count every ack pulse, sampled on the falling edge.
    always @(negedge clk) begin
        if (ack) ack_count++;
    end

    // The upstream bridge never raises read and write together.
    always @(posedge clk) begin
        if (rst_n && accept) begin
            assert (!(rd && (wr != 4'h0))) else begin
                bad++;
                $error("[TB] FAIL upstream_rd_wr_overlap observed rd=%0b wr=%h expected no overlap", rd, wr);
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic checkBit(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] s_wr, input logic s_rd, input logic [7:0] s_len,
                                 input logic [31:0] s_addr, input logic [31:0] s_data);
        wr    = s_wr;
        rd    = s_rd;
        len   = s_len;
        addr  = s_addr;
        wdata = s_data;
    endtask

    initial begin
        rst_n = 1'b0;
        applyStimulus(4'h0, 1'b0, 8'd0, 32'h0, 32'h0);
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
        arready = 1'b0; rvalid = 1'b0; rdata = 32'h0; rresp = 2'b00;

        // Reset values
        tick; tick;
        checkBit("rst_accept", accept, 1'b1);
        checkBit("rst_awvalid", awvalid, 1'b0);
        checkBit("rst_wvalid", wvalid, 1'b0);
        checkBit("rst_arvalid", arvalid, 1'b0);
        checkBit("rst_bready", bready, 1'b0);
        checkBit("rst_rready", rready, 1'b0);
        checkBit("rst_ack", ack, 1'b0);
        checkBit("rst_error", error, 1'b0);
        checkOutput("rst_read_data", read_data, 32'h0);
        @(negedge clk) rst_n = 1'b1;
        tick;

        // Minimum-latency write with a ready slave
        $display("[TB] write, ready slave");
        awready = 1'b1; wready = 1'b1;
        applyStimulus(4'hF, 1'b0, 8'd0, 32'h8000_0010, 32'hDEAD_BEEF);
        checkBit("t1_accept_idle", accept, 1'b1);
        tick;
        applyStimulus(4'h0, 1'b0, 8'd0, 32'h0, 32'h0);
        checkBit("t1_awvalid", awvalid, 1'b1);
        checkBit("t1_wvalid", wvalid, 1'b1);
        checkOutput("t1_awaddr", awaddr, 32'h8000_0010);
        checkOutput("t1_wdata", axi_wdata, 32'hDEAD_BEEF);
        checkOutput("t1_wstrb", {28'h0, wstrb}, 32'hF);
        checkBit("t1_accept_e1", accept, 1'b0);
        bvalid = 1'b1; bresp = 2'b00;
        tick;
        checkBit("t1_awvalid_clr", awvalid, 1'b0);
        checkBit("t1_wvalid_clr", wvalid, 1'b0);
        checkBit("t1_bready", bready, 1'b1);
        checkBit("t1_accept_e2", accept, 1'b0);
        checkBit("t1_no_early_ack", ack, 1'b0);
        tick;
        checkBit("t1_ack", ack, 1'b1);
        checkBit("t1_error", error, 1'b0);
        checkBit("t1_accept_e3", accept, 1'b1);
        checkBit("t1_bready_drop", bready, 1'b0);
        bvalid = 1'b0; awready = 1'b0; wready = 1'b0;
        tick;
        checkBit("t1_ack_pulse", ack, 1'b0);

        // W completes three cycles before AW; slave answers SLVERR
        $display("[TB] write, W before AW, error response");
        n0 = ack_count;
        wready = 1'b1;
        applyStimulus(4'h3, 1'b0, 8'd0, 32'h8000_0020, 32'h1122_3344);
        tick;
        applyStimulus(4'h0, 1'b0, 8'd0, 32'h0, 32'h0);
        checkBit("t2_awvalid_e1", awvalid, 1'b1);
        checkBit("t2_wvalid_e1", wvalid, 1'b1);
        tick;
        checkBit("t2_wvalid_drop", wvalid, 1'b0);
        checkBit("t2_awvalid_hold_e2", awvalid, 1'b1);
        tick;
        checkBit("t2_awvalid_hold_e3", awvalid, 1'b1);
        checkBit("t2_no_ack_e3", ack, 1'b0);
        tick;
        checkBit("t2_awvalid_hold_e4", awvalid, 1'b1);
        checkOutput("t2_awaddr_stable", awaddr, 32'h8000_0020);
        checkOutput("t2_wstrb", {28'h0, wstrb}, 32'h3);
        awready = 1'b1;
        tick;
        checkBit("t2_awvalid_clr", awvalid, 1'b0);
        checkBit("t2_bready", bready, 1'b1);
        awready = 1'b0; bvalid = 1'b1; bresp = 2'b10;
        tick;
        checkBit("t2_ack", ack, 1'b1);
        checkBit("t2_error", error, 1'b1);
        bvalid = 1'b0; bresp = 2'b00; wready = 1'b0;
        tick;
        checkOutput("t2_one_ack", 32'(ack_count - n0), 32'd1);

        // Read with AR delayed two cycles, then a write that must not touch read data
        $display("[TB] read, delayed arready");
        applyStimulus(4'h0, 1'b1, 8'd0, 32'h0000_1004, 32'h0);
        tick;
        applyStimulus(4'h0, 1'b0, 8'd0, 32'h0, 32'h0);
        checkBit("t3_arvalid_e1", arvalid, 1'b1);
        checkOutput("t3_araddr", araddr, 32'h0000_1004);
        tick;
        checkBit("t3_arvalid_e2", arvalid, 1'b1);
        tick;
        checkBit("t3_arvalid_e3", arvalid, 1'b1);
        arready = 1'b1;
        tick;
        checkBit("t3_arvalid_clr", arvalid, 1'b0);
        checkBit("t3_rready", rready, 1'b1);
        arready = 1'b0; rvalid = 1'b1; rdata = 32'h1234_5678; rresp = 2'b00;
        tick;
        checkBit("t3_ack", ack, 1'b1);
        checkBit("t3_error", error, 1'b0);
        checkOutput("t3_read_data", read_data, 32'h1234_5678);
        checkBit("t3_rready_drop", rready, 1'b0);
        rvalid = 1'b0; rdata = 32'h0;
        awready = 1'b1; wready = 1'b1;
        applyStimulus(4'hF, 1'b0, 8'd0, 32'h8000_0030, 32'hA5A5_A5A5);
        tick;
        applyStimulus(4'h0, 1'b0, 8'd0, 32'h0, 32'h0);
        bvalid = 1'b1;
        tick;
        tick;
        checkBit("t3w_ack", ack, 1'b1);
        checkOutput("t3w_read_data_kept", read_data, 32'h1234_5678);
        bvalid = 1'b0; awready = 1'b0; wready = 1'b0;
        tick;

        // Illegal burst length: error ack without AXI traffic
        $display("[TB] read with len=3");
        arready = 1'b1;
        applyStimulus(4'h0, 1'b1, 8'd3, 32'h0000_0040, 32'h0);
        tick;
        applyStimulus(4'h0, 1'b0, 8'd0, 32'h0, 32'h0);
        checkBit("t4_arvalid_e1", arvalid, 1'b0);
        checkBit("t4_accept_e1", accept, 1'b0);
        tick;
        checkBit("t4_ack", ack, 1'b1);
        checkBit("t4_error", error, 1'b1);
        checkBit("t4_accept_e2", accept, 1'b1);
        checkBit("t4_arvalid_e2", arvalid, 1'b0);
        arready = 1'b0;
        tick;

        // Slave never answers B: timeout ack on the eighth edge after WREQ entry
        $display("[TB] write timeout");
        n0 = ack_count;
        awready = 1'b1; wready = 1'b1;
        applyStimulus(4'hF, 1'b0, 8'd0, 32'h8000_0040, 32'h0BAD_F00D);
        tick;
        applyStimulus(4'h0, 1'b0, 8'd0, 32'h0, 32'h0);
        seen = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            tick;
            seen = seen | ack;
        end
        checkBit("t5_no_early_ack", seen, 1'b0);
        tick;
        checkBit("t5_ack", ack, 1'b1);
        checkBit("t5_error", error, 1'b1);
        checkBit("t5_bready_drop", bready, 1'b0);
        awready = 1'b0; wready = 1'b0;
        bvalid = 1'b1;
        tick;
        checkBit("t5_late_b_bready", bready, 1'b0);
        checkBit("t5_late_b_ack", ack, 1'b0);
        tick;
        bvalid = 1'b0;
        checkOutput("t5_one_ack", 32'(ack_count - n0), 32'd1);

        // Asynchronous reset while waiting in RRESP
        $display("[TB] reset during read");
        arready = 1'b1;
        applyStimulus(4'h0, 1'b1, 8'd0, 32'h0000_2000, 32'h0);
        tick;
        applyStimulus(4'h0, 1'b0, 8'd0, 32'h0, 32'h0);
        checkBit("t6_arvalid", arvalid, 1'b1);
        tick;
        arready = 1'b0;
        checkBit("t6_rready", rready, 1'b1);
        n0 = ack_count;
        #2 rst_n = 1'b0;
        #1;
        checkBit("t6_async_arvalid", arvalid, 1'b0);
        checkBit("t6_async_rready", rready, 1'b0);
        checkBit("t6_async_ack", ack, 1'b0);
        checkBit("t6_async_accept", accept, 1'b1);
        tick;
        @(negedge clk) rst_n = 1'b1;
        tick;
        checkBit("t6_idle_after", accept, 1'b1);
        checkOutput("t6_no_ack_inflight", 32'(ack_count - n0), 32'd0);
        checkOutput("t6_read_data_reset", read_data, 32'h0);
        arready = 1'b1; rvalid = 1'b1; rdata = 32'hCAFE_F00D; rresp = 2'b00;
        applyStimulus(4'h0, 1'b1, 8'd0, 32'h0000_2000, 32'h0);
        tick;
        applyStimulus(4'h0, 1'b0, 8'd0, 32'h0, 32'h0);
        checkBit("t6b_arvalid", arvalid, 1'b1);
        tick;
        checkBit("t6b_rready", rready, 1'b1);
        tick;
        checkBit("t6b_ack", ack, 1'b1);
        checkBit("t6b_error", error, 1'b0);
        checkOutput("t6b_read_data", read_data, 32'hCAFE_F00D);
        arready = 1'b0; rvalid = 1'b0;
        tick;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
